phase_4_post_adder: RTL and testbench
=====================================

// Module: phase_4_post_adder
// PURPOSE
//  Final DSP48A1 slice stage, directly downstream of the M-register / X-Z mux stage.
//  Adds or subtracts X and carry-in from Z, registers the 48-bit sum into P, registers
//  carry-out, and drives P and PCOUT. PCOUT feeds back as the X/Z-mux accumulate source.
// PARAMETERS
//  C_WIDTH      48         datapath width of X, Z, P, PCOUT
//  CARRYINSEL   "OPMODE5"  carry source: "OPMODE5" = opmode_5, "CARRYIN" = carryin port; other -> 0
//  CARRYINREG   1          1 = carry-in through CYI register; 0 = combinational
//  PREG         1          1 = P registered; 0 = P combinational from adder
//  CARRYOUTREG  1          1 = carryout/carryoutf registered; 0 = combinational
// PORTS
//  clk          in   1        single clock, rising edge
//  rstp         in   1        sync active-high reset, P register
//  rstcarryin   in   1        sync active-high reset, CYI and carry-out registers
//  cep          in   1        clock enable, P register
//  cecarryin    in   1        clock enable, CYI and carry-out registers
//  mux_x_out    in   C_WIDTH  X operand from X mux
//  mux_z_out    in   C_WIDTH  Z operand from Z mux
//  opmode_5     in   1        carry-in value when CARRYINSEL="OPMODE5"
//  opmode_7     in   1        0 = add (Z+(X+CIN)), 1 = subtract (Z-(X+CIN))
//  carryin      in   1        external/cascade carry-in
//  P            out  C_WIDTH  post-adder result
//  PCOUT        out  C_WIDTH  cascade out, always equal to P
//  carryout     out  1        adder bit C_WIDTH
//  carryoutf    out  1        fabric copy, always equal to carryout
// BEHAVIOUR
//  - All registers synchronous to clk; a reset beats its enable in the same cycle.
//  - Reset values: P=PCOUT=0, carryout=carryoutf=0, CYI=0.
//  - cin_src = opmode_5 or carryin per CARRYINSEL; illegal string -> constant 0.
//  - CYI: if rstcarryin then 0, elsif cecarryin then cin_src, else hold; bypassed if CARRYINREG=0.
//  - Arithmetic, width C_WIDTH+1, operands zero-extended, CIN = CYI output:
//    opmode_7=0: sum = {0,Z} + {0,X} + CIN; opmode_7=1: sum = {0,Z} - ({0,X} + CIN).
//    Sub result is modulo 2^(C_WIDTH+1); carryout = sum[C_WIDTH] (borrow when subtracting).
//  - P register: if rstp then 0, elsif cep then sum[C_WIDTH-1:0], else hold.
//  - Carry-out register: rstcarryin / cecarryin control, loads sum[C_WIDTH].
//  - Latency (all regs=1): X/Z -> P = 1 clk. opmode_5 -> P = 2 clk (CYI + PREG).
//  - Accumulate: upstream Z=PCOUT, X=M; each cep cycle P <= P+M, so no comb. loop with PREG=1.
//  - Wrap: Z=2^48-1, X=1, add -> P=0, carryout=1. No saturation.
//  - Hold: cep=0 freezes P even if operands change; cecarryin=0 freezes CYI and carryout.
//  - Reset mid-accumulate: rstp clears P; the next enabled cycle accumulates from 0.
//  - rstp and rstcarryin are independent; asserting only one leaves the other domain's regs intact.
// CONFIGURATION
//  - Macro PHASE4_ZERO_DETECT_EN defined: extra output p_zero (1 bit). It is registered with the
//    P register controls (rstp/cep), reset 0, and is 1 when the loaded sum[C_WIDTH-1:0]==0.
//    It is combinational when PREG=0.
//  - Macro not defined: no p_zero port and no logic.
// TESTING
//  1. rstp=rstcarryin=1 for 2 clk with all inputs nonzero -> P=PCOUT=0, carryout=0.
//  2. Add: X=5, Z=10, opmode_7=0, opmode_5=1, OPMODE5 -> CYI=1 after clk1, P=16 after clk2.
//  3. Sub: X=3, Z=10, opmode_7=1, CIN=1 -> P=6, carryout=0.
//     X=11, Z=10, CIN=0 -> P=48'hFFFF_FFFF_FFFF, carryout=1.
//  4. Wrap: X=1, Z=48'hFFFF_FFFF_FFFF, add, CIN=0 -> P=0, carryout=1, p_zero=1 (macro on).
//  5. Accumulate: Z=PCOUT, X=7, cep=1 for 4 clk from P=0 -> 7, 14, 21, 28. Then cep=0 -> holds 28.
//     Then rstp=1 with cep=1 -> P=0.
//  6. Sweep CARRYINREG/PREG/CARRYOUTREG = 0/1 and CARRYINSEL="CARRYIN" -> latency per BEHAVIOUR,
//     PCOUT==P and carryoutf==carryout on every cycle.

Source files
------------

// File: rtl/phase_4_post_adder.sv
// DSP48A1-style post-adder stage: Z +/- (X + CIN) into a 48-bit P register with carry-out.
// Define PHASE4_ZERO_DETECT_EN to add the p_zero output (result-equals-zero flag).
module phase_4_post_adder #(
    parameter int    C_WIDTH     = 48,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter int    CARRYINREG  = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYOUTREG = 1
) (
    input  logic               clk,
    input  logic               rstp,
    input  logic               rstcarryin,
    input  logic               cep,
    input  logic               cecarryin,
    input  logic [C_WIDTH-1:0] mux_x_out,
    input  logic [C_WIDTH-1:0] mux_z_out,
    input  logic               opmode_5,
    input  logic               opmode_7,
    input  logic               carryin,
    output logic [C_WIDTH-1:0] P,
    output logic [C_WIDTH-1:0] PCOUT,
    output logic               carryout,
    output logic               carryoutf
`ifdef PHASE4_ZERO_DETECT_EN
   ,output logic               p_zero
`endif
);

    logic             cin_src;
    logic             cin;
    logic [C_WIDTH:0] sum;

    // Only one of the two carry sources is used by any given CARRYINSEL setting.
    logic unused_cin_inputs;
    assign unused_cin_inputs = ^{opmode_5, carryin};

    generate
        if (CARRYINSEL == "OPMODE5") begin : g_cin_op5
            assign cin_src = opmode_5;
        end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
            assign cin_src = carryin;
        end else begin : g_cin_zero
            assign cin_src = 1'b0;
        end

        if (CARRYINREG == 1) begin : g_cyi_reg
            logic cyi;
            // NOTE: reset is tested before the enable so a reset always wins over a load.
            always_ff @(posedge clk) begin
                if (rstcarryin)     cyi <= 1'b0;
                else if (cecarryin) cyi <= cin_src;
            end
            assign cin = cyi;
        end else begin : g_cyi_comb
            assign cin = cin_src;
        end
    endgenerate

    // One bit wider than the operands so bit C_WIDTH is the carry (add) or borrow (subtract).
    always_comb begin
        if (opmode_7)
            sum = {1'b0, mux_z_out} - ({1'b0, mux_x_out} + {{C_WIDTH{1'b0}}, cin});
        else
            sum = {1'b0, mux_z_out} + {1'b0, mux_x_out} + {{C_WIDTH{1'b0}}, cin};
    end

    generate
        if (PREG == 1) begin : g_preg
            logic [C_WIDTH-1:0] p_q;
            always_ff @(posedge clk) begin
                if (rstp)     p_q <= '0;
                else if (cep) p_q <= sum[C_WIDTH-1:0];
            end
            assign P = p_q;
        end else begin : g_pcomb
            assign P = sum[C_WIDTH-1:0];
        end

        if (CARRYOUTREG == 1) begin : g_coreg
            logic co_q;
            always_ff @(posedge clk) begin
                if (rstcarryin)     co_q <= 1'b0;
                else if (cecarryin) co_q <= sum[C_WIDTH];
            end
            assign carryout = co_q;
        end else begin : g_cocomb
            assign carryout = sum[C_WIDTH];
        end
    endgenerate

    assign PCOUT     = P;
    assign carryoutf = carryout;

`ifdef PHASE4_ZERO_DETECT_EN
    // The flag tracks whatever P holds, so it shares the P register controls.
    generate
        if (PREG == 1) begin : g_pzero_reg
            logic pz_q;
            always_ff @(posedge clk) begin
                if (rstp)     pz_q <= 1'b0;
                else if (cep) pz_q <= ~|sum[C_WIDTH-1:0];
            end
            assign p_zero = pz_q;
        end else begin : g_pzero_comb
            assign p_zero = ~|sum[C_WIDTH-1:0];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_phase_4_post_adder.sv
// Scoreboard bench for phase_4_post_adder: four configurations driven with the same stimulus,
// expected outputs queued by a cycle-level arithmetic model and compared by a monitor process.
module tb_phase_4_post_adder;

    localparam int W = 48;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    // Configurations: 0 = OPMODE5 all regs, 1 = CARRYIN all comb, 2 = CARRYIN CYI+CO regs,
    // 3 = illegal select with P reg only.
    localparam int       SEL[4] = '{0, 1, 1, 2};
    localparam logic [3:0] CINREG = 4'b0101;
    localparam logic [3:0] PREGB  = 4'b1001;
    localparam logic [3:0] COREG  = 4'b0101;

    typedef struct packed {
        logic [3:0][W-1:0] p;
        logic [3:0]        co;
        logic [3:0]        pz;
    } exp_t;

    logic clk = 1'b0;
    logic rstp = 1'b0, rstcarryin = 1'b0, cep = 1'b0, cecarryin = 1'b0;
    logic [W-1:0] x_drv = '0, z_drv = '0;
    logic op5 = 1'b0, op7 = 1'b0, cin_drv = 1'b0, acc = 1'b0;

    logic [W-1:0] p_o  [4];
    logic [W-1:0] pc_o [4];
    logic         co_o [4];
    logic         cof_o[4];
    logic         pz_o [4];
    logic [W-1:0] z0;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;

    logic [W-1:0] m_p  [4] = '{default: '0};
    logic         m_cyi[4] = '{default: 1'b0};
    logic         m_co [4] = '{default: 1'b0};
    logic         m_pz [4] = '{default: 1'b0};

    always #5 clk = ~clk;

    // Configuration 0 can run as an accumulator by feeding its own PCOUT back as Z.
    assign z0 = acc ? pc_o[0] : z_drv;

`ifndef PHASE4_ZERO_DETECT_EN
    initial for (int k = 0; k < 4; k++) pz_o[k] = 1'b0;
`endif

    phase_4_post_adder #(.C_WIDTH(W), .CARRYINSEL("OPMODE5"), .CARRYINREG(1), .PREG(1), .CARRYOUTREG(1)) u_d0 (
        .clk(clk), .rstp(rstp), .rstcarryin(rstcarryin), .cep(cep), .cecarryin(cecarryin),
        .mux_x_out(x_drv), .mux_z_out(z0), .opmode_5(op5), .opmode_7(op7), .carryin(cin_drv),
        .P(p_o[0]), .PCOUT(pc_o[0]), .carryout(co_o[0]), .carryoutf(cof_o[0])
`ifdef PHASE4_ZERO_DETECT_EN
       ,.p_zero(pz_o[0])
`endif
    );

    phase_4_post_adder #(.C_WIDTH(W), .CARRYINSEL("CARRYIN"), .CARRYINREG(0), .PREG(0), .CARRYOUTREG(0)) u_d1 (
        .clk(clk), .rstp(rstp), .rstcarryin(rstcarryin), .cep(cep), .cecarryin(cecarryin),
        .mux_x_out(x_drv), .mux_z_out(z_drv), .opmode_5(op5), .opmode_7(op7), .carryin(cin_drv),
        .P(p_o[1]), .PCOUT(pc_o[1]), .carryout(co_o[1]), .carryoutf(cof_o[1])
`ifdef PHASE4_ZERO_DETECT_EN
       ,.p_zero(pz_o[1])
`endif
    );

    phase_4_post_adder #(.C_WIDTH(W), .CARRYINSEL("CARRYIN"), .CARRYINREG(1), .PREG(0), .CARRYOUTREG(1)) u_d2 (
        .clk(clk), .rstp(rstp), .rstcarryin(rstcarryin), .cep(cep), .cecarryin(cecarryin),
        .mux_x_out(x_drv), .mux_z_out(z_drv), .opmode_5(op5), .opmode_7(op7), .carryin(cin_drv),
        .P(p_o[2]), .PCOUT(pc_o[2]), .carryout(co_o[2]), .carryoutf(cof_o[2])
`ifdef PHASE4_ZERO_DETECT_EN
       ,.p_zero(pz_o[2])
`endif
    );

    phase_4_post_adder #(.C_WIDTH(W), .CARRYINSEL("BOGUS"), .CARRYINREG(0), .PREG(1), .CARRYOUTREG(0)) u_d3 (
        .clk(clk), .rstp(rstp), .rstcarryin(rstcarryin), .cep(cep), .cecarryin(cecarryin),
        .mux_x_out(x_drv), .mux_z_out(z_drv), .opmode_5(op5), .opmode_7(op7), .carryin(cin_drv),
        .P(p_o[3]), .PCOUT(pc_o[3]), .carryout(co_o[3]), .carryoutf(cof_o[3])
`ifdef PHASE4_ZERO_DETECT_EN
       ,.p_zero(pz_o[3])
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: Z +/- (X + CIN) modulo 2^49, returned as {carry, result}.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] z,
                                           input logic sub, input logic c);
        longint unsigned a, b, r;
        a = longint'(z);
        b = longint'(x) + longint'(c);
        r = sub ? (a - b) : (a + b);
        return r[W:0];
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue what every DUT must show after
    // the next rising edge.
    task automatic drive(input logic rp, input logic rc, input logic cp, input logic cc,
                         input logic [W-1:0] x, input logic [W-1:0] z,
                         input logic o5, input logic o7, input logic ci, input logic ac);
        exp_t e;
        logic cs, c_pre, c_post, n_cyi, n_co, n_pz;
        logic [W-1:0] zz, n_p;
        logic [W:0] s_pre, s_post;
        @(negedge clk);
        rstp = rp; rstcarryin = rc; cep = cp; cecarryin = cc;
        x_drv = x; z_drv = z; op5 = o5; op7 = o7; cin_drv = ci; acc = ac;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            cs     = (SEL[k] == 0) ? o5 : (SEL[k] == 1) ? ci : 1'b0;
            c_pre  = CINREG[k] ? m_cyi[k] : cs;
            zz     = (k == 0 && ac) ? m_p[0] : z;
            s_pre  = ref_sum(x, zz, o7, c_pre);
            n_cyi  = rc ? 1'b0 : (cc ? cs : m_cyi[k]);
            n_p    = rp ? '0 : (cp ? s_pre[W-1:0] : m_p[k]);
            n_pz   = rp ? 1'b0 : (cp ? (s_pre[W-1:0] == '0) : m_pz[k]);
            n_co   = rc ? 1'b0 : (cc ? s_pre[W] : m_co[k]);
            c_post = CINREG[k] ? n_cyi : cs;
            s_post = ref_sum(x, zz, o7, c_post);
            e.p[k]  = PREGB[k] ? n_p  : s_post[W-1:0];
            e.pz[k] = PREGB[k] ? n_pz : (s_post[W-1:0] == '0);
            e.co[k] = COREG[k] ? n_co : s_post[W];
            m_cyi[k] = n_cyi; m_p[k] = n_p; m_pz[k] = n_pz; m_co[k] = n_co;
        end
        sb_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle is an output beat; compare after the rising edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                check($sformatf("d%0d_p", k),         64'(p_o[k]),   64'(e.p[k]));
                check($sformatf("d%0d_pcout", k),     64'(pc_o[k]),  64'(e.p[k]));
                check($sformatf("d%0d_carryout", k),  64'(co_o[k]),  64'(e.co[k]));
                check($sformatf("d%0d_carryoutf", k), 64'(cof_o[k]), 64'(e.co[k]));
`ifdef PHASE4_ZERO_DETECT_EN
                check($sformatf("d%0d_p_zero", k),    64'(pz_o[k]),  64'(e.pz[k]));
`endif
            end
        end
    end

    function automatic logic [W-1:0] rand_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return ONES;
            2:       return {{(W-1){1'b0}}, 1'b1};
            default: return r[W-1:0];
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every other input nonzero.
        repeat (2) drive(1, 1, 1, 1, 48'd123, 48'd456, 1, 0, 1, 0);
        settle();
        check("reset_p",        64'(p_o[0]),  64'd0);
        check("reset_pcout",    64'(pc_o[0]), 64'd0);
        check("reset_carryout", 64'(co_o[0]), 64'd0);

        // Add with CIN from opmode_5: CYI loads first, so P reaches 16 on the second edge.
        drive(0, 0, 1, 1, 48'd5, 48'd10, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 48'd5, 48'd10, 1, 0, 0, 0);
        settle();
        check("add_p", 64'(p_o[0]), 64'd16);

        // Subtract with CIN=1, then a borrow with CIN=0.
        repeat (2) drive(0, 0, 1, 1, 48'd3, 48'd10, 1, 1, 0, 0);
        settle();
        check("sub_p",        64'(p_o[0]),  64'd6);
        check("sub_carryout", 64'(co_o[0]), 64'd0);
        repeat (2) drive(0, 0, 1, 1, 48'd11, 48'd10, 0, 1, 0, 0);
        settle();
        check("borrow_p",        64'(p_o[0]),  64'(ONES));
        check("borrow_carryout", 64'(co_o[0]), 64'd1);

        // Wrap past 2^48 - 1.
        repeat (2) drive(0, 0, 1, 1, 48'd1, ONES, 0, 0, 0, 0);
        settle();
        check("wrap_p",        64'(p_o[0]),  64'd0);
        check("wrap_carryout", 64'(co_o[0]), 64'd1);

        // Accumulate X=7 from P=0, hold, then reset mid-accumulate.
        drive(1, 0, 1, 1, 48'd7, '0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 1, 1, 48'd7, '0, 0, 0, 0, 1);
            settle();
            check($sformatf("acc_step%0d", i), 64'(p_o[0]), 64'(7 * i));
        end
        repeat (2) drive(0, 0, 0, 1, 48'd7, '0, 0, 0, 0, 1);
        settle();
        check("acc_hold", 64'(p_o[0]), 64'd28);
        drive(1, 0, 1, 1, 48'd7, '0, 0, 0, 0, 1);
        settle();
        check("acc_reset", 64'(p_o[0]), 64'd0);

        // Random traffic, including independent resets and enables.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) != 0,  $urandom_range(0, 3) != 0,
                  rand_op(), rand_op(), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0);
        end

        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
